// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data memory controller and its lane aligner.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    byte_en    = 4'b0000;
    wword      = wdata;
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wword   = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        wword      = {2{wdata[15:0]}};
        misaligned = lane[0];
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        misaligned = (lane != 2'b00);
      end
      default: byte_en = 4'b0000;
    endcase
  end

  assign rd_byte = rword[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rdata_ext = rword;
    unique case (size)
      SZ_BYTE: rdata_ext = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: rdata_ext = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rdata_ext = rword;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed MIPS data memory with valid/ready request port and fixed wait states.
module data_memory_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH          = 100,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LATENCY        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned TEST_WORD      = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       test_value
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH];

  logic              accept;
  logic              live_op;
  logic              do_access;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_uns;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [IDX_W-1:0]  op_idx;
  logic [SEL_W-1:0]  word_sel;
  logic              out_of_range;
  logic              misaligned;
  logic              op_err;
  logic              mem_we;
  logic [3:0]        byte_en;
  logic [31:0]       wword;
  logic [31:0]       rd_word;
  logic [31:0]       rdata_ext;

  assign req_ready = (state_q != StWait);
  assign accept    = req_valid & req_ready;

  // With no wait states the access happens on the accept edge, so use the live request.
  assign live_op  = accept && (LATENCY == 0);
  assign op_we    = live_op ? req_we       : we_q;
  assign op_size  = live_op ? req_size     : size_q;
  assign op_uns   = live_op ? req_unsigned : uns_q;
  assign op_addr  = live_op ? req_addr     : addr_q;
  assign op_wdata = live_op ? req_wdata    : wdata_q;

  assign op_idx       = op_addr[ADDR_W-1:2];
  assign word_sel     = op_idx[SEL_W-1:0];
  assign out_of_range = (op_idx >= DEPTH_IDX);
  assign rd_word      = mem_q[word_sel];
  assign op_err       = misaligned | (op_size == SZ_ILLEGAL) | out_of_range;
  assign mem_we       = do_access & op_we & ~op_err;

  mem_lane_align u_align (
    .wdata      (op_wdata),
    .size       (op_size),
    .lane       (op_addr[1:0]),
    .is_unsigned(op_uns),
    .rword      (rd_word),
    .byte_en    (byte_en),
    .wword      (wword),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          cnt_d = 4'd0;
          if (LATENCY == 0) begin
            state_d   = StResp;
            do_access = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == LAT_LAST) begin
          state_d   = StResp;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata_q <= (op_err || op_we) ? 32'h0 : rdata_ext;
      rsp_err_q   <= op_err;
    end
  end

  if (CLEAR_ON_RESET != 0) begin : g_clear
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 32'h0;
      end else if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem_q[word_sel][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end else begin : g_keep
    always_ff @(posedge clk) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem_q[word_sel][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

  assign rsp_valid  = (state_q == StResp);
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign test_value = mem_q[TEST_WORD][15:0];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: three controller instances with different latency/reset options.
module tb_data_memory_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_we       [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_addr     [3];
  logic [31:0] req_wdata    [3];
  logic        rsp_valid    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_err      [3];
  logic [15:0] test_value   [3];

  exp_t q [3][$];
  int   lat [3] = '{0, 3, 2};
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  data_memory_ctrl #(.DEPTH(100), .LATENCY(0), .CLEAR_ON_RESET(1), .TEST_WORD(0)) u_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .test_value(test_value[0])
  );

  data_memory_ctrl #(.DEPTH(100), .LATENCY(3), .CLEAR_ON_RESET(1), .TEST_WORD(0)) u_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .test_value(test_value[1])
  );

  data_memory_ctrl #(.DEPTH(100), .LATENCY(2), .CLEAR_ON_RESET(0), .TEST_WORD(4)) u_c (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .test_value(test_value[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare every response pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int d = 0; d < 3; d++) begin
        if (rsp_valid[d]) begin
          if (q[d].size() == 0) begin
            check_eq($sformatf("spurious_rsp%0d", d), 32'(rsp_valid[d]), 32'h0);
          end else begin
            exp_t e;
            e = q[d].pop_front();
            check_eq($sformatf("rdata%0d", d), rsp_rdata[d], e.rdata);
            check_eq($sformatf("err%0d", d), 32'(rsp_err[d]), 32'(e.err));
            check_eq($sformatf("latency%0d", d), 32'(cyc - e.acc), 32'(lat[d] + 1));
          end
        end
      end
    end
  end

  task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    int guard = 0;
    @(negedge clk);
    req_we[d]       = we;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wd;
    req_valid[d]    = 1'b1;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[d]) begin
      check_eq("ready_timeout", 32'(req_ready[d]), 32'h1);
      req_valid[d] = 1'b0;
      return;
    end
    q[d].push_back('{rdata: exp_rd, err: exp_err, acc: cyc});
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    check_eq("drain", 32'(q[0].size() + q[1].size() + q[2].size()), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d]    = 1'b0;
      req_we[d]       = 1'b0;
      req_size[d]     = 2'b00;
      req_unsigned[d] = 1'b0;
      req_addr[d]     = 32'h0;
      req_wdata[d]    = 32'h0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready[0]), 32'h1);
    check_eq("rst_valid", 32'(rsp_valid[0]), 32'h0);
    check_eq("rst_rdata", rsp_rdata[0], 32'h0);
    check_eq("rst_err", 32'(rsp_err[0]), 32'h0);
    reset_n = 1'b1;

    // Zero wait states: back-to-back accesses
    issue(0, 1, 2'b10, 0, 32'h0, 32'h8000F0FF, 32'h0, 0);
    drain();
    check_eq("test_value_sw", 32'(test_value[0]), 32'h0000F0FF);
    issue(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h8000F0FF, 0);
    issue(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 0);
    issue(0, 0, 2'b00, 1, 32'h0, 32'h0, 32'h000000FF, 0);
    issue(0, 0, 2'b01, 0, 32'h2, 32'h0, 32'hFFFF8000, 0);
    issue(0, 0, 2'b01, 1, 32'h2, 32'h0, 32'h00008000, 0);
    issue(0, 1, 2'b00, 0, 32'h1, 32'h000000AA, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h8000AAFF, 0);
    issue(0, 0, 2'b00, 0, 32'h1, 32'h0, 32'hFFFFFFAA, 0);
    issue(0, 1, 2'b01, 0, 32'h6, 32'hFFFF1234, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h4, 32'h0, 32'h12340000, 0);
    issue(0, 0, 2'b10, 0, 32'h2, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b01, 0, 32'h3, 32'h00005555, 32'h0, 1);
    issue(0, 1, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b10, 0, 32'd400, 32'h0, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h8000AAFF, 0);
    drain();
    check_eq("test_value_sb", 32'(test_value[0]), 32'h0000AAFF);

    // Three wait states: ready drops for the wait cycles
    issue(1, 1, 2'b10, 0, 32'h0, 32'h11112222, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("wait_ready", 32'(req_ready[1]), 32'h0);
    end
    issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h11112222, 0);
    drain();

    // No-clear instance keeps its contents through reset
    issue(2, 1, 2'b10, 0, 32'h10, 32'hCAFEBABE, 32'h0, 0);
    drain();
    check_eq("test_value_c", 32'(test_value[2]), 32'h0000BABE);

    // Reset while a store waits: it must vanish without writing or responding
    issue(1, 1, 2'b10, 0, 32'h8, 32'h5A5A5A5A, 32'h0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    q[1].delete();
    #1;
    check_eq("midrst_valid", 32'(rsp_valid[1]), 32'h0);
    check_eq("midrst_ready", 32'(req_ready[1]), 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("post_rst_valid", 32'(rsp_valid[1]), 32'h0);
    end
    issue(1, 0, 2'b10, 0, 32'h8, 32'h0, 32'h0, 0);
    issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 0);
    issue(2, 0, 2'b10, 0, 32'h10, 32'h0, 32'hCAFEBABE, 0);
    drain();
    check_eq("test_value_kept", 32'(test_value[2]), 32'h0000BABE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, byte-addressed MIPS data memory with a valid/ready request port and a configurable number of wait states.
Supports lw/lh/lhu/lb/lbu/sw/sh/sb through size, unsigned and byte-lane logic, and flags misaligned or out-of-range accesses.
Sits between the MEM stage and the data array, replacing the single-cycle word-indexed memory.
Keeps the 16-bit debug tap used by the board bring-up.

Parameters:
DEPTH, 100, number of 32-bit words in the array.
ADDR_W, 32, width of the byte address.
LATENCY, 0, wait states between request accept and response (0..15).
CLEAR_ON_RESET, 1, if 1 the reset zeroes every word; if 0 array contents survive reset.
TEST_WORD, 0, word index driven onto test_value.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for word and stores
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  out  1  request was misaligned, out of range or had an illegal size
test_value  out  16  RAM[TEST_WORD][15:0], combinational

Behaviour:
- Reset is clk/reset_n, asynchronous and active-low. During reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. The array is zeroed when CLEAR_ON_RESET=1.
- Reset mid-operation discards the pending request; no write occurs and no response is issued.
- FSM states are IDLE, WAIT and RESP.
  - A request is accepted on a clk edge with req_valid & req_ready. At that edge the block latches we, size, unsigned, addr and wdata.
  - After accept, the FSM goes to WAIT if LATENCY>0, else to RESP.
  - WAIT counts LATENCY cycles, then goes to RESP.
- rsp_valid is high for exactly one cycle, LATENCY+1 cycles after the accept edge.
- The array write and the read sampling both happen on the edge that raises rsp_valid.
  - A load issued right after a store to the same word therefore returns the new data.
  - A store's effect is visible to test_value from that edge.
- req_ready=1 in IDLE and RESP, and 0 in WAIT.
  - Accepting in RESP gives back-to-back operation: one access per LATENCY+1 cycles.
  - With LATENCY=0 this is one access per cycle.
  - There is no response back-pressure; the pipeline stalls on req_ready.
- Address mapping: word index = addr[ADDR_W-1:2], lane = addr[1:0], little-endian (lane 0 = bits[7:0]).
- Error cases:
  - size=01 with addr[0]=1.
  - size=10 with addr[1:0]!=0.
  - size=11.
  - word index >= DEPTH.
  - On error: rsp_err=1, rsp_rdata=0, array unchanged.
- Stores use a byte-lane write:
  - sb writes one lane from wdata[7:0].
  - sh writes lanes {1,0} or {3,2} from wdata[15:0].
  - sw writes all four lanes.
  - Other lanes are preserved.
- Loads extract the lane(s), then extend:
  - Sign-extend from bit 7 or 15 when req_unsigned=0, zero-extend otherwise.
  - Word loads are unmodified.
- rsp_rdata and rsp_err hold their values until the next response. Consumers qualify them with rsp_valid.
- Address bits above the index range are used only for the range check.

Decomposition:
- Shared package mips_mem_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding for IDLE/WAIT/RESP.
- Sub-module mem_lane_align (purely combinational) handles both directions:
  - Store path: wdata, size and lane in; 4-bit byte-enable and lane-shifted write word out.
  - Load path: read word, size, lane and unsigned in; extended result out.
  - It also produces the misalignment flag.
- data_memory_ctrl keeps the FSM, wait counter, latched request, array and range check.

Test Plan:
- LATENCY=0: sw 0x8000F0FF @0x0, then lw @0x0 on the next cycle -> rsp_valid one cycle after each accept; rdata=0x8000F0FF; test_value=0xF0FF.
- Extension: after the sw above, lb @0x0 -> 0xFFFFFFFF; lbu @0x0 -> 0x000000FF; lh @0x2 -> 0xFFFF8000; lhu @0x2 -> 0x00008000.
- Partial store: sb 0xAA @0x1, then lw @0x0 -> 0x8000AAFF.
- Misaligned and range errors (rsp_err=1, rdata=0, following lw shows the word unchanged):
  - lw @0x2
  - sh @0x3
  - size=11
  - sw @4*DEPTH
- LATENCY=3: accept at cycle 0 -> req_ready=0 in cycles 1-3; rsp_valid only in cycle 4; a second request accepted in cycle 4 responds in cycle 8.
- Reset: assert reset_n=0 during WAIT of a pending sw -> no rsp_valid; after release, lw of that address reads 0 (CLEAR_ON_RESET=1). With CLEAR_ON_RESET=0, a previously stored word survives.
